deadtime_gen: RTL and testbench
===============================

DEADTIME_GEN -- requirements
Module: deadtime_gen

Interface
REQ-001 Parameter: DT_BITS, default 8, width of the dead-time count.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: en  input  1  bridge enable; 0 forces both switches off.
REQ-005 Port: pwm_in  input  1  PWM command from the upstream PWM generator (1 = high side on).
REQ-006 Port: dt  input  DT_BITS  dead time in clk cycles; sampled when a dead interval starts.
REQ-007 Port: hs_out  output  1  high-side gate drive, registered.
REQ-008 Port: ls_out  output  1  low-side gate drive, registered.
REQ-009 Port: busy  output  1  1 while a dead interval is in progress, registered.

Function
REQ-010 The FSM SHALL have the states OFF, LOW, DT_LH, HIGH and DT_HL.
REQ-011 Outputs SHALL come from registers computed from the next state, so they change on the same edge as the state.
REQ-012 Output decode SHALL be: ls_out=1 only in LOW; hs_out=1 only in HIGH; busy=1 only in DT_LH or DT_HL.
REQ-013 hs_out and ls_out SHALL never both be 1 in any cycle, including across reset and en changes.
REQ-014 en=0 sampled on an edge SHALL send the FSM to OFF on that edge from any state; this has the highest priority.
REQ-015 In OFF with en=1, the FSM SHALL go to HIGH if pwm_in=1, else to LOW, on the next edge.
REQ-016 In LOW with pwm_in=1, the FSM SHALL go to DT_LH and load the down-counter with max(dt,1)-1.
REQ-017 In HIGH with pwm_in=0, the FSM SHALL go to DT_HL and load the down-counter with max(dt,1)-1.
REQ-018 In DT_LH/DT_HL the counter SHALL decrement each cycle; at counter==0 the FSM SHALL go to HIGH or LOW respectively.
REQ-019 Both outputs SHALL therefore be 0 for exactly max(dt,1) cycles per dead interval; dt=0 SHALL be treated as 1.
REQ-020 Abort rule: pwm_in=0 in DT_LH SHALL return the FSM to LOW on the next edge; pwm_in=1 in DT_HL SHALL return it to HIGH.
REQ-021 A pwm_in pulse shorter than the dead time SHALL be swallowed with no output toggle; this behaviour is required.
REQ-022 A dt change during a dead interval SHALL be ignored until the next interval starts.
REQ-023 Latency from a pwm_in edge to the state/output change SHALL be 1 clk edge, plus 2 cycles when the synchronizer is compiled in.
REQ-024 The counter SHALL be DT_BITS wide and SHALL never wrap; decrementing stops at 0.

Reset
REQ-025 While rst=1: state=OFF, hs_out=0, ls_out=0, busy=0, counter=0, synchronizer flops=0.
REQ-026 After rst deasserts, the first transition SHALL follow REQ-015 on the first rising edge.
REQ-027 rst asserted mid dead interval SHALL force all outputs low immediately, without waiting for a clock edge.

Configuration
REQ-028 With macro DEADTIME_SYNC_EN defined, pwm_in and en SHALL each pass through a two-flop synchronizer, adding 2 cycles of latency.
REQ-029 Without DEADTIME_SYNC_EN, pwm_in and en SHALL be sampled directly, since they come from the same clk domain.

Verification (DT_BITS=8, no DEADTIME_SYNC_EN unless stated)
REQ-030 Reset, then en=1, pwm_in=0 -> ls_out=1 after 1 edge; hs_out=0; busy=0.
REQ-031 dt=4, LOW, pwm_in 0->1 held -> ls_out=0 next edge; both outputs 0 for exactly 4 cycles (busy=1); then hs_out=1.
REQ-032 dt=4, HIGH, pwm_in pulses low for 2 cycles -> hs_out off for 2 dead cycles, FSM aborts to HIGH; ls_out never 1.
REQ-033 dt=0 and dt=255 -> dead interval of exactly 1 and 255 cycles respectively.
REQ-034 en=0 during DT_LH, then rst pulse mid-interval -> both outputs 0 at once; the hs_out&ls_out assertion never fires across a 10k-cycle random pwm_in/dt run.
REQ-035 DEADTIME_SYNC_EN defined, repeat REQ-031 -> identical waveform shifted by 2 cycles.

Source files
------------

// File: rtl/deadtime_gen.sv
// Half-bridge dead-time generator: turns one PWM command into complementary
// high/low gate drives with a programmable dead interval. Define DEADTIME_SYNC_EN to add
// two-flop synchronizers on pwm_in and en.
module deadtime_gen #(
    parameter int DT_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               pwm_in,
    input  logic [DT_BITS-1:0] dt,
    output logic               hs_out,
    output logic               ls_out,
    output logic               busy
);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        LOW   = 3'd1,
        DT_LH = 3'd2,
        HIGH  = 3'd3,
        DT_HL = 3'd4
    } state_t;

    localparam logic [DT_BITS-1:0] CNT_ONE = DT_BITS'(1);

    logic               pwm_s;
    logic               en_s;
    state_t             state_q;
    state_t             state_d;
    logic [DT_BITS-1:0] cnt_q;
    logic [DT_BITS-1:0] cnt_d;
    logic               hs_q;
    logic               ls_q;
    logic               busy_q;

    // Counter preload: dt=0 still yields one dead cycle.
    function automatic logic [DT_BITS-1:0] dt_load(input logic [DT_BITS-1:0] d);
        if (d == '0) begin
            dt_load = '0;
        end else begin
            dt_load = d - CNT_ONE;
        end
    endfunction

`ifdef DEADTIME_SYNC_EN
    logic [1:0] pwm_sync_q;
    logic [1:0] en_sync_q;

    // Two-flop synchronizers for asynchronous pwm_in and en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_sync_q <= 2'b00;
            en_sync_q  <= 2'b00;
        end else begin
            pwm_sync_q <= {pwm_sync_q[0], pwm_in};
            en_sync_q  <= {en_sync_q[0], en};
        end
    end

    assign pwm_s = pwm_sync_q[1];
    assign en_s  = en_sync_q[1];
`else
    assign pwm_s = pwm_in;
    assign en_s  = en;
`endif

    // Next-state and dead-time counter logic; disable overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en_s) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = pwm_s ? HIGH : LOW;
                    cnt_d   = '0;
                end
                LOW: begin
                    if (pwm_s) begin
                        state_d = DT_LH;
                        cnt_d   = dt_load(dt);
                    end else begin
                        state_d = LOW;
                    end
                end
                DT_LH: begin
                    if (!pwm_s) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = HIGH;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!pwm_s) begin
                        state_d = DT_HL;
                        cnt_d   = dt_load(dt);
                    end else begin
                        state_d = HIGH;
                    end
                end
                DT_HL: begin
                    if (pwm_s) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = LOW;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and outputs decoded from the next state so they switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hs_q    <= (state_d == HIGH);
            ls_q    <= (state_d == LOW);
            busy_q  <= (state_d == DT_LH) || (state_d == DT_HL);
        end
    end

    assign hs_out = hs_q;
    assign ls_out = ls_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_deadtime_gen.sv
// Directed self-checking bench for deadtime_gen; the expected latencies follow
// DEADTIME_SYNC_EN when that macro is defined for the build.
module tb_deadtime_gen;

`ifdef DEADTIME_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       pwm_in;
    logic [7:0] dt;
    logic       hs_out;
    logic       ls_out;
    logic       busy;

    int errors  = 0;
    int checks  = 0;
    int overlap = 0;
    int n;
    int dead;
    int ls_seen;

    always #5 clk = ~clk;

    deadtime_gen #(.DT_BITS(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .pwm_in (pwm_in),
        .dt     (dt),
        .hs_out (hs_out),
        .ls_out (ls_out),
        .busy   (busy)
    );

    // Shoot-through monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (hs_out && ls_out) overlap++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts consecutive samples with both gates off, bounded at 300.
    task automatic measure_dead(output int cnt);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (hs_out || ls_out) break;
            cnt++;
            step(1);
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        pwm_in = 1'b0;
        dt     = 8'd4;
        step(3);
        check_val("reset_hs", {31'd0, hs_out}, 32'd0);
        check_val("reset_ls", {31'd0, ls_out}, 32'd0);
        check_val("reset_busy", {31'd0, busy}, 32'd0);

        // Release reset with en=1, pwm=0: first edge goes to LOW.
        rst = 1'b0;
        en  = 1'b1;
        step(1 + LAT);
        check_val("start_ls", {31'd0, ls_out}, 32'd1);
        check_val("start_hs", {31'd0, hs_out}, 32'd0);
        check_val("start_busy", {31'd0, busy}, 32'd0);

        // LOW -> HIGH with dt=4.
        pwm_in = 1'b1;
        step(1 + LAT);
        check_val("lh_ls_off", {31'd0, ls_out}, 32'd0);
        check_val("lh_busy", {31'd0, busy}, 32'd1);
        measure_dead(n);
        check_val("lh_dead_len", n, 32'd4);
        check_val("lh_hs_on", {31'd0, hs_out}, 32'd1);
        check_val("lh_busy_end", {31'd0, busy}, 32'd0);

        // Short low pulse in HIGH is swallowed: 2 dead cycles, back to HIGH.
        dead    = 0;
        ls_seen = 0;
        pwm_in  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (i == 1) pwm_in = 1'b1;
            if (!hs_out) dead++;
            if (ls_out) ls_seen++;
        end
        check_val("abort_dead", dead, 32'd2);
        check_val("abort_ls_never", ls_seen, 32'd0);
        check_val("abort_hs_back", {31'd0, hs_out}, 32'd1);

        // dt=0 acts as one dead cycle.
        dt     = 8'd0;
        pwm_in = 1'b0;
        step(1 + LAT);
        measure_dead(n);
        check_val("dt0_len", n, 32'd1);
        check_val("dt0_ls_on", {31'd0, ls_out}, 32'd1);

        // dt=255; a dt change mid-interval must be ignored.
        dt     = 8'd255;
        pwm_in = 1'b1;
        step(1 + LAT);
        dt = 8'd2;
        measure_dead(n);
        check_val("dt255_len", n, 32'd255);
        check_val("dt255_hs_on", {31'd0, hs_out}, 32'd1);

        // HIGH -> LOW with dt=1.
        dt     = 8'd1;
        pwm_in = 1'b0;
        step(1 + LAT);
        measure_dead(n);
        check_val("dt1_len", n, 32'd1);
        check_val("dt1_ls_on", {31'd0, ls_out}, 32'd1);

        // en=0 during DT_LH forces OFF.
        dt     = 8'd4;
        pwm_in = 1'b1;
        step(1 + LAT);
        check_val("en_dt_busy", {31'd0, busy}, 32'd1);
        en = 1'b0;
        step(1 + LAT);
        check_val("en_off_hs", {31'd0, hs_out}, 32'd0);
        check_val("en_off_ls", {31'd0, ls_out}, 32'd0);
        check_val("en_off_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        step(1 + LAT);
        check_val("off_to_high", {31'd0, hs_out}, 32'd1);

        // Async reset mid dead interval clears outputs without an edge.
        pwm_in = 1'b0;
        step(1 + LAT);
        check_val("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #2;
        check_val("rst_async_hs", {31'd0, hs_out}, 32'd0);
        check_val("rst_async_ls", {31'd0, ls_out}, 32'd0);
        check_val("rst_async_busy", {31'd0, busy}, 32'd0);
        step(2);
        rst = 1'b0;
        step(1 + LAT);
        check_val("rst_restart_ls", {31'd0, ls_out}, 32'd1);

        // Random pwm/dt/en soak for shoot-through.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) pwm_in = ~pwm_in;
            dt = 8'($urandom_range(0, 7));
            en = ($urandom_range(0, 99) != 0);
            step(1);
        end
        check_val("no_overlap", overlap, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
